// File: rtl/rijndael_pkg.sv
// Shared types and helpers for the Rijndael inverse key schedule.
// Contains the GF(2^8) arithmetic used by the S-box and the round-constant inverse.
package rijndael_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_e;

    function automatic int unsigned nsteps(input int unsigned nk);
        case (nk)
            4:       return 10;
            6:       return 8;
            8:       return 7;
            default: return 0;
        endcase
    endfunction

    // Undoes one xtime: the forward schedule doubles rc in GF(2^8).
    function automatic logic [7:0] rcinv(input logic [7:0] r);
        return (r >> 1) ^ (r[0] ? 8'h8D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

endpackage

// File: rtl/rijndael_invkeyschedulestep.sv
// One backward key-schedule step: recovers the previous key state from the current one.
module rijndael_invkeyschedulestep
    import rijndael_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic [32*NK-1:0] keystate_i,
    input  logic [7:0]       rc_i,
    output logic [32*NK-1:0] prev_keystate_o
);

    localparam int unsigned KEYSIZE = WORD_W * NK;

    logic [WORD_W-1:0] last_prev_c;
    logic [WORD_W-1:0] rot_c;
    logic [WORD_W-1:0] sub_rot_c;
    logic [WORD_W-1:0] sub_n3_c;

    // P[NK-1] is needed before P[0], since P[0] depends on it.
    assign last_prev_c = keystate_i[KEYSIZE-1 -: WORD_W] ^ keystate_i[KEYSIZE-WORD_W-1 -: WORD_W];
    assign rot_c       = {last_prev_c[23:0], last_prev_c[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox_rot
        rijndael_sbox u_sbox (
            .in_i  (rot_c[8*b +: 8]),
            .out_o (sub_rot_c[8*b +: 8])
        );
    end

    if (NK == 8) begin : g_nk8
        for (genvar b = 0; b < 4; b++) begin : g_sbox_n3
            rijndael_sbox u_sbox (
                .in_i  (keystate_i[96 + 8*b +: 8]),
                .out_o (sub_n3_c[8*b +: 8])
            );
        end
    end else begin : g_nk_std
        assign sub_n3_c = '0;
    end

    always_comb begin
        prev_keystate_o = '0;
        for (int i = 1; i < int'(NK); i++) begin
            prev_keystate_o[32*i +: 32] = keystate_i[32*i +: 32]
                ^ ((NK == 8 && i == 4) ? sub_n3_c : keystate_i[32*(i-1) +: 32]);
        end
        prev_keystate_o[31:0] = keystate_i[31:0] ^ {sub_rot_c[31:24] ^ rc_i, sub_rot_c[23:0]};
    end

endmodule

// File: rtl/rijndael_sbox.sv
// Forward AES S-box computed as GF(2^8) inverse followed by the affine transform.
module rijndael_sbox
    import rijndael_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] inv_c;

    assign inv_c = gf_inv(in_i);
    assign out_o = inv_c
                 ^ {inv_c[6:0], inv_c[7]}
                 ^ {inv_c[5:0], inv_c[7:6]}
                 ^ {inv_c[4:0], inv_c[7:5]}
                 ^ {inv_c[3:0], inv_c[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/rijndael_invkeyschedule.sv
// Streams the key states of a Rijndael schedule backwards, newest first, down to the cipher key.
module rijndael_invkeyschedule
    import rijndael_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [32*NK-1:0] keystate_i,
    input  logic [7:0]       rc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [32*NK-1:0] keystate_o,
    output logic             last_o
);

    localparam int unsigned KEYSIZE = WORD_W * NK;
    localparam int unsigned NSTEPS  = nsteps(NK);

    ks_state_e          state_q, state_d;
    logic [KEYSIZE-1:0] key_q, key_d;
    logic [7:0]         rc_q, rc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [KEYSIZE-1:0] prev_c;

    rijndael_invkeyschedulestep #(
        .NK (NK)
    ) u_step (
        .keystate_i      (key_q),
        .rc_i            (rc_q),
        .prev_keystate_o (prev_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // last_q is precomputed so last_o comes straight from a flop.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    key_d   = keystate_i;
                    rc_d    = rc_i;
                    cnt_d   = CNT_W'(NSTEPS);
                    last_d  = 1'b0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready_i) begin
                    if (cnt_q == '0) begin
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        key_d  = prev_c;
                        rc_d   = rcinv(rc_q);
                        cnt_d  = cnt_q - CNT_W'(1);
                        last_d = (cnt_q == CNT_W'(1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_EMIT);
    assign keystate_o  = key_q;
    assign last_o      = last_q;

endmodule

// File: tb/tb_rijndael_invkeyschedule.sv
// Directed bench for the inverse key schedule at NK=4, 6 and 8.
module tb_rijndael_invkeyschedule;
    import rijndael_pkg::*;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         out_ready [3];
    logic [255:0] ks_in     [3];
    logic [7:0]   rc_in     [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         last      [3];
    logic [255:0] ko        [3];
    wire  [127:0] ko4;
    wire  [191:0] ko6;
    wire  [255:0] ko8;

    assign ko[0] = {128'b0, ko4};
    assign ko[1] = {64'b0, ko6};
    assign ko[2] = ko8;

    rijndael_invkeyschedule #(.NK(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .keystate_i(ks_in[0][127:0]), .rc_i(rc_in[0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .keystate_o(ko4), .last_o(last[0]));
    rijndael_invkeyschedule #(.NK(6)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .keystate_i(ks_in[1][191:0]), .rc_i(rc_in[1]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .keystate_o(ko6), .last_o(last[1]));
    rijndael_invkeyschedule #(.NK(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .keystate_i(ks_in[2]), .rc_i(rc_in[2]), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready[2]), .keystate_o(ko8), .last_o(last[2]));

    int n_chk  = 0;
    int n_pass = 0;
    logic [255:0] exp_st [0:10];
    logic [7:0]   rc_chain [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    localparam logic [255:0] AES_KEY  = {128'b0, 128'h09cf4f3cabf7158828aed2a62b7e1516};
    localparam logic [255:0] AES_FIN  = {128'b0, 128'hb6630ca6e13f0cc8c9ee2589d014f9a8};
    localparam logic [255:0] AES_R9   = {128'b0, 128'h575c006e28d1294119fadc21ac7766f3};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic int tb_ns(input int nk);
        return (nk == 4) ? 10 : (nk == 6) ? 8 : 7;
    endfunction

    // Forward FIPS-197 schedule step, word by word.
    function automatic logic [255:0] fwd(input logic [255:0] s, input int nk, input logic [7:0] rc);
        logic [31:0]  w [8];
        logic [31:0]  n [8];
        logic [31:0]  t;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin w[i] = s[32*i +: 32]; n[i] = '0; end
        t    = subw({w[nk-1][23:0], w[nk-1][31:24]}) ^ {rc, 24'h0};
        n[0] = w[0] ^ t;
        for (int i = 1; i < nk; i++)
            n[i] = w[i] ^ ((nk == 8 && i == 4) ? subw(n[3]) : n[i-1]);
        r = '0;
        for (int i = 0; i < nk; i++) r[32*i +: 32] = n[i];
        return r;
    endfunction

    task automatic prep(input int nk, input logic [255:0] key, output logic [7:0] rc_fin);
        logic [255:0] st [0:10];
        logic [7:0]   rc;
        int           ns;
        ns    = tb_ns(nk);
        st[0] = key;
        rc    = 8'h01;
        rc_fin = 8'h01;
        for (int j = 1; j <= ns; j++) begin
            st[j]  = fwd(st[j-1], nk, rc);
            rc_fin = rc;
            rc     = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        for (int b = 0; b <= ns; b++) exp_st[b] = st[ns-b];
    endtask

    task automatic load(input int k, input logic [255:0] ks, input logic [7:0] rc);
        int w = 0;
        out_ready[k] = 1'b0;
        ks_in[k]     = ks;
        rc_in[k]     = rc;
        while (!in_ready[k] && w < 100) begin @(negedge clk); w++; end
        if (!in_ready[k]) chk("load_wait", 0, 1);
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        chk("first_valid", 256'(out_valid[k]), 1);
        chk("busy_ready", 256'(in_ready[k]), 0);
    endtask

    // Consumes beats [0, stop) with random ready at duty%, checking hold during stalls.
    task automatic collect(input int k, input int nbeats, input int stop, input int duty);
        int           beat = 0;
        int           cyc  = 0;
        logic         stall = 1'b0;
        logic         rdy;
        logic         hlast = 1'b0;
        logic [255:0] held = '0;
        while (beat < stop && cyc < 3000) begin
            if (stall) begin
                chk("stall_data", ko[k], held);
                chk("stall_last", 256'(last[k]), 256'(hlast));
            end
            rdy = ($urandom_range(99) < duty);
            out_ready[k] = rdy;
            stall = 1'b0;
            if (out_valid[k]) begin
                if (rdy) begin
                    chk($sformatf("dut%0d_beat%0d", k, beat), ko[k], exp_st[beat]);
                    chk($sformatf("dut%0d_last%0d", k, beat), 256'(last[k]), 256'(beat == nbeats - 1));
                    beat++;
                end else begin
                    stall = 1'b1;
                    held  = ko[k];
                    hlast = last[k];
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (beat < stop) chk("beat_timeout", 256'(beat), 256'(stop));
        out_ready[k] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   rc_f;
        logic [255:0] key;
        logic [255:0] other;
        int           nk;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; ks_in[k] = '0; rc_in[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 256'(in_ready[0]), 1);
        chk("rst_out_valid", 256'(out_valid[0]), 0);
        chk("rst_keystate", ko[0], 0);
        chk("rst_last", 256'(last[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            chk($sformatf("rcinv_%0d", i), 256'(rcinv(rc_chain[i])), 256'(rc_chain[i+1]));

        // AES-128 known answer; hand constants override the model at beats 0, 1 and 10.
        prep(4, AES_KEY, rc_f);
        exp_st[0]  = AES_FIN;
        exp_st[1]  = AES_R9;
        exp_st[10] = AES_KEY;
        load(0, AES_FIN, 8'h36);
        collect(0, 11, 11, 100);
        chk("end_valid", 256'(out_valid[0]), 0);
        chk("end_ready", 256'(in_ready[0]), 1);

        load(0, AES_FIN, 8'h36);
        collect(0, 11, 11, 30);

        for (int k = 0; k < 3; k++) begin
            nk  = 4 + 2 * k;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            key = key & ((256'(1) << (32 * nk)) - 256'(1));
            prep(nk, key, rc_f);
            load(k, exp_st[0], rc_f);
            collect(k, tb_ns(nk) + 1, tb_ns(nk) + 1, (k == 2) ? 30 : 100);
            chk($sformatf("rt%0d_idle", nk), 256'(out_valid[k]), 0);
        end

        // Load request held through the stream is ignored until the last beat completes.
        prep(4, AES_KEY, rc_f);
        other = {128'b0, $urandom, $urandom, $urandom, $urandom};
        out_ready[0] = 1'b0;
        ks_in[0] = AES_FIN; rc_in[0] = 8'h36; in_valid[0] = 1'b1;
        @(negedge clk);
        chk("busy_first_valid", 256'(out_valid[0]), 1);
        ks_in[0] = other; rc_in[0] = 8'h01;
        collect(0, 11, 11, 100);
        chk("reload_ready", 256'(in_ready[0]), 1);
        chk("reload_gap", 256'(out_valid[0]), 0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("reload_valid", 256'(out_valid[0]), 1);
        chk("reload_data", ko[0], other);
        out_ready[0] = 1'b1;
        repeat (12) @(negedge clk);
        out_ready[0] = 1'b0;

        // Asynchronous reset while beat 4 is presented.
        load(0, AES_FIN, 8'h36);
        collect(0, 11, 4, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 256'(out_valid[0]), 0);
        chk("midrst_ready", 256'(in_ready[0]), 1);
        chk("midrst_data", ko[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 256'(in_ready[0]), 1);
        chk("post_rst_valid", 256'(out_valid[0]), 0);
        load(0, AES_FIN, 8'h36);
        collect(0, 11, 11, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
